train_track_emulator: RTL

TRAIN_TRACK_EMULATOR -- requirements
Module: train_track_emulator

---
 rtl/train_pkg.sv | 27 ++
 rtl/segment_timer.sv | 27 ++
 rtl/train_track_emulator.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/train_pkg.sv
// Shared definitions for the train track emulator: FSM states, sensor
// count and the segment-time multipliers selected by speed_sel.
package train_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    TRAVEL = 2'd2,
    DONE   = 2'd3
  } track_state_e;

  localparam int NUM_SENSORS = 6;

  localparam logic [2:0] MULT_4X = 3'd4;
  localparam logic [2:0] MULT_2X = 3'd2;
  localparam logic [2:0] MULT_1X = 3'd1;

  // Map the 2-bit speed select onto a multiple of the base segment time.
  function automatic logic [2:0] speed_mult(input logic [1:0] sel);
    case (sel)
      2'd0:    return MULT_4X;
      2'd1:    return MULT_2X;
      default: return MULT_1X;
    endcase
  endfunction

endpackage

// File: rtl/segment_timer.sv
// Loadable 16-bit down-counter with a zero flag; times both the sensor
// pulses and the travel segments between sensors.
module segment_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        en_i,
  output logic        zero_o
);

  logic [15:0] count_q;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != 16'd0)) begin
      count_q <= count_q - 16'd1;
    end
  end

  assign zero_o = (count_q == 16'd0);

endmodule

// File: rtl/train_track_emulator.sv
// Train track emulator: walks a single train past sensors S1..S6, holding
// each sensor high for PULSE_LEN cycles with a travel gap between them.
// Optional build macro TRACK_NOISE_EN adds a high/low glitch before each
// sensor pulse.
module train_track_emulator
  import train_pkg::*;
#(
  parameter int SEG_BASE  = 1000,
  parameter int PULSE_LEN = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [1:0] speed_sel,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic       S5,
  output logic       S6,
  output logic       busy,
  output logic       done,
  output logic [3:0] lap_count
);

`ifdef TRACK_NOISE_EN
  // Timer covers the two glitch cycles plus the real pulse.
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_LEN + 1);
`else
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_LEN - 1);
`endif
  localparam logic [2:0] LAST_IDX = 3'(NUM_SENSORS);

  track_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [3:0]   lap_q, lap_d;
  logic         tmr_load, tmr_en, tmr_zero;
  logic [15:0]  tmr_val, travel_load;
  logic         sensor_on;

  assign travel_load = 16'(SEG_BASE) * {13'd0, speed_mult(speed_sel)} - 16'd1;

  segment_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // State, sensor index and lap counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd1;
      lap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lap_q   <= lap_d;
    end
  end

  // Next-state logic: launch, pulse/travel sequencing, lap wrap and abort.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lap_d    = lap_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d  = PULSE;
          idx_d    = 3'd1;
          lap_d    = 4'd0;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end
      end
      PULSE: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = 3'd1;
        end else if (tmr_zero) begin
          if ((idx_q == LAST_IDX) && !loop_en) begin
            state_d = DONE;
          end else begin
            if (idx_q == LAST_IDX) begin
              lap_d = lap_q + 4'd1;
            end
            state_d  = TRAVEL;
            tmr_load = 1'b1;
            tmr_val  = travel_load;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      TRAVEL: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = 3'd1;
        end else if (tmr_zero) begin
          idx_d    = (idx_q == LAST_IDX) ? 3'd1 : idx_q + 3'd1;
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = 3'd1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef TRACK_NOISE_EN
  logic [1:0] glitch_q;

  // Glitch phase: 2 = first high cycle, 1 = forced low cycle, 0 = real pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 2'd0;
    end else if (tmr_load && (state_d == PULSE)) begin
      glitch_q <= 2'd2;
    end else if ((state_q == PULSE) && (glitch_q != 2'd0)) begin
      glitch_q <= glitch_q - 2'd1;
    end
  end

  assign sensor_on = (state_q == PULSE) && (glitch_q != 2'd1);
`else
  assign sensor_on = (state_q == PULSE);
`endif

  assign S1        = sensor_on && (idx_q == 3'd1);
  assign S2        = sensor_on && (idx_q == 3'd2);
  assign S3        = sensor_on && (idx_q == 3'd3);
  assign S4        = sensor_on && (idx_q == 3'd4);
  assign S5        = sensor_on && (idx_q == 3'd5);
  assign S6        = sensor_on && (idx_q == 3'd6);
  assign busy      = (state_q == PULSE) || (state_q == TRAVEL);
  assign done      = (state_q == DONE);
  assign lap_count = lap_q;

endmodule
